mem_access_ctrl: RTL and testbench

- MEM-stage data-memory request controller. It sits directly upstream of the load-data masking stage.
- Converts a MEM-stage load/store (opcode, byte address, rt data) into a word-aligned data-cache request: big-endian byte write enables and lane-replicated store data.
- Holds the request stable across cache stalls and freezes the pipeline while it waits.
- Delivers the registered load opcode and byte offset so they line up with the cache's read data the cycle after the request is accepted.

---
 rtl/mem_access_ctrl.sv | 154 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store to data-cache request controller with stall hold and load-return tagging
//   clk, rst          : clock, synchronous active-high reset
//   req_valid, opcode, addr, store_data : MEM-stage memory op
//   dc_stall          : cache cannot accept a request this cycle
//   dc_addr/dc_re/dc_we/dc_din : word-aligned cache request, big-endian byte enables
//   mem_stall         : freeze upstream pipeline
//   misaligned        : combinational alignment exception
//   ld_valid/ld_opcode/ld_byte_offset : registered tag aligned with cache read data
//   timeout_err       : sticky stall-timeout flag
module mem_access_ctrl #(
  parameter int STALL_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [5:0]  opcode,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic        dc_stall,
  output logic [31:0] dc_addr,
  output logic        dc_re,
  output logic [3:0]  dc_we,
  output logic [31:0] dc_din,
  output logic        mem_stall,
  output logic        misaligned,
  output logic        ld_valid,
  output logic [5:0]  ld_opcode,
  output logic [1:0]  ld_byte_offset,
  output logic        timeout_err
);
  localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24, LHU = 6'h25;
  localparam logic [5:0] SB = 6'h28, SH = 6'h29, SW = 6'h2B;
  localparam int CW = $clog2(STALL_TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(STALL_TIMEOUT);
  typedef enum logic {IDLE, HOLD} state_e;
  state_e state_q, state_d;
  logic [31:0] hold_addr_q, hold_addr_d, hold_din_q, hold_din_d;
  logic [3:0]  hold_we_q, hold_we_d;
  logic        hold_re_q, hold_re_d;
  logic [5:0]  hold_op_q, hold_op_d;
  logic [1:0]  hold_off_q, hold_off_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        timeout_q, timeout_d;
  logic        ld_valid_q, ld_valid_d;
  logic [5:0]  ld_opcode_q, ld_opcode_d;
  logic [1:0]  ld_off_q, ld_off_d;
  logic        is_load, is_store, need_h, need_w, aligned, op_ok;
  logic [31:0] req_addr, req_din;
  logic [3:0]  req_we;
  always_comb begin
    is_load  = opcode inside {LB, LH, LW, LBU, LHU};
    is_store = opcode inside {SB, SH, SW};
    need_h   = opcode inside {LH, LHU, SH};
    need_w   = opcode inside {LW, SW};
    aligned  = !(need_h && addr[0]) && !(need_w && |addr[1:0]);
    op_ok    = req_valid && (is_load || is_store) && aligned;
    req_addr = {addr[31:2], 2'b00};
    req_we   = (opcode == SB) ? (4'b1000 >> addr[1:0]) :
               (opcode == SH) ? (addr[1] ? 4'b0011 : 4'b1100) :
               (opcode == SW) ? 4'b1111 : 4'b0000;
    req_din  = (opcode == SB) ? {4{store_data[7:0]}} :
               (opcode == SH) ? {2{store_data[15:0]}} :
               (opcode == SW) ? store_data : 32'h0;
  end
  always_comb begin
    state_d     = state_q;
    hold_addr_d = hold_addr_q;
    hold_din_d  = hold_din_q;
    hold_we_d   = hold_we_q;
    hold_re_d   = hold_re_q;
    hold_op_d   = hold_op_q;
    hold_off_d  = hold_off_q;
    cnt_d       = cnt_q;
    timeout_d   = timeout_q;
    ld_valid_d  = 1'b0;
    ld_opcode_d = 6'h00;
    ld_off_d    = 2'b00;
    dc_addr     = req_addr;
    dc_re       = 1'b0;
    dc_we       = 4'b0000;
    dc_din      = 32'h0;
    mem_stall   = 1'b0;
    misaligned  = 1'b0;
    if (rst) begin
      state_d   = IDLE;
      cnt_d     = '0;
      timeout_d = 1'b0;
    end else if (state_q == IDLE) begin
      misaligned = req_valid && (is_load || is_store) && !aligned;
      dc_re      = op_ok && is_load;
      dc_we      = op_ok ? req_we : 4'b0000;
      dc_din     = op_ok ? req_din : 32'h0;
      mem_stall  = op_ok && dc_stall;
      if (op_ok && dc_stall) begin
        state_d     = HOLD;
        hold_addr_d = req_addr;
        hold_re_d   = is_load;
        hold_we_d   = req_we;
        hold_din_d  = req_din;
        hold_op_d   = opcode;
        hold_off_d  = addr[1:0];
        cnt_d       = CW'(1);
        timeout_d   = timeout_q | (TMAX == CW'(1));
      end else if (op_ok && is_load) begin
        ld_valid_d  = 1'b1;
        ld_opcode_d = opcode;
        ld_off_d    = addr[1:0];
      end
    end else begin
      dc_addr   = hold_addr_q;
      dc_re     = hold_re_q;
      dc_we     = hold_we_q;
      dc_din    = hold_din_q;
      mem_stall = dc_stall;
      if (dc_stall) begin
        cnt_d     = (cnt_q == TMAX) ? cnt_q : cnt_q + CW'(1);
        timeout_d = timeout_q | (cnt_d == TMAX);
      end else begin
        state_d     = IDLE;
        cnt_d       = '0;
        ld_valid_d  = hold_re_q;
        ld_opcode_d = hold_re_q ? hold_op_q : 6'h00;
        ld_off_d    = hold_re_q ? hold_off_q : 2'b00;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
      ld_valid_q  <= 1'b0;
      ld_opcode_q <= 6'h00;
      ld_off_q    <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
      ld_valid_q  <= ld_valid_d;
      ld_opcode_q <= ld_opcode_d;
      ld_off_q    <= ld_off_d;
    end
    hold_addr_q <= hold_addr_d;
    hold_din_q  <= hold_din_d;
    hold_we_q   <= hold_we_d;
    hold_re_q   <= hold_re_d;
    hold_op_q   <= hold_op_d;
    hold_off_q  <= hold_off_d;
  end
  assign ld_valid       = ld_valid_q;
  assign ld_opcode      = ld_opcode_q;
  assign ld_byte_offset = ld_off_q;
  assign timeout_err    = timeout_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: scoreboard bench for mem_access_ctrl
module tb_mem_access_ctrl;
  logic clk = 1'b0, rst, req_valid, dc_stall;
  logic [5:0] opcode;
  logic [31:0] addr, store_data;
  logic [31:0] dc_addr, dc_din;
  logic dc_re, mem_stall, misaligned, ld_valid, timeout_err;
  logic [3:0] dc_we;
  logic [5:0] ld_opcode;
  logic [1:0] ld_byte_offset;
  int checks = 0, errors = 0;
  typedef struct {logic [31:0] a; logic re; logic [3:0] we; logic [31:0] din;} req_t;
  typedef struct {logic [5:0] op; logic [1:0] off;} ld_t;
  req_t rq[$];
  ld_t lq[$];
  mem_access_ctrl #(.STALL_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .opcode(opcode), .addr(addr),
    .store_data(store_data), .dc_stall(dc_stall), .dc_addr(dc_addr), .dc_re(dc_re),
    .dc_we(dc_we), .dc_din(dc_din), .mem_stall(mem_stall), .misaligned(misaligned),
    .ld_valid(ld_valid), .ld_opcode(ld_opcode), .ld_byte_offset(ld_byte_offset),
    .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic push_req(input logic [31:0] a, input logic re, input logic [3:0] we, input logic [31:0] din);
    req_t r;
    r.a = a; r.re = re; r.we = we; r.din = din;
    rq.push_back(r);
  endtask
  task automatic push_ld(input logic [5:0] op, input logic [1:0] off);
    ld_t l;
    l.op = op; l.off = off;
    lq.push_back(l);
  endtask
  always @(negedge clk) begin
    if (!rst && (dc_re || dc_we != 4'b0) && !dc_stall) begin
      if (rq.size() == 0) chk("unexpected_req", {31'b0, dc_re} | {28'b0, dc_we}, 32'h0);
      else begin
        req_t r;
        r = rq.pop_front();
        chk("req_addr", dc_addr, r.a);
        chk("req_re", {31'b0, dc_re}, {31'b0, r.re});
        chk("req_we", {28'b0, dc_we}, {28'b0, r.we});
        chk("req_din", dc_din, r.din);
      end
    end
    if (!rst && ld_valid) begin
      if (lq.size() == 0) chk("unexpected_ld", {31'b0, ld_valid}, 32'h0);
      else begin
        ld_t l;
        l = lq.pop_front();
        chk("ld_opcode", {26'b0, ld_opcode}, {26'b0, l.op});
        chk("ld_off", {30'b0, ld_byte_offset}, {30'b0, l.off});
      end
    end
  end
  initial begin
    rst = 1; req_valid = 1; opcode = 6'h23; addr = 32'h0; store_data = 32'h0; dc_stall = 0;
    @(negedge clk);
    chk("rst_dc_re", {31'b0, dc_re}, 0);
    chk("rst_mem_stall", {31'b0, mem_stall}, 0);
    tick;
    rst = 0; req_valid = 0;
    @(negedge clk);
    chk("rst_ld_valid", {31'b0, ld_valid}, 0);
    chk("rst_ld_opcode", {26'b0, ld_opcode}, 0);
    chk("rst_timeout", {31'b0, timeout_err}, 0);
    tick;
    req_valid = 1; opcode = 6'h28; addr = 32'h1003; store_data = 32'hAABBCCDD;
    push_req(32'h1000, 0, 4'b0001, 32'hDDDDDDDD);
    @(negedge clk);
    chk("sb_mem_stall", {31'b0, mem_stall}, 0);
    chk("sb_misaligned", {31'b0, misaligned}, 0);
    tick;
    opcode = 6'h29; addr = 32'h2002; store_data = 32'h00001234;
    push_req(32'h2000, 0, 4'b0011, 32'h12341234);
    @(negedge clk);
    chk("sb_no_ld_valid", {31'b0, ld_valid}, 0);
    tick;
    opcode = 6'h23; addr = 32'h2002;
    @(negedge clk);
    chk("mis_flag", {31'b0, misaligned}, 1);
    chk("mis_dc_re", {31'b0, dc_re}, 0);
    chk("mis_mem_stall", {31'b0, mem_stall}, 0);
    tick;
    req_valid = 0;
    @(negedge clk);
    chk("mis_ld_valid", {31'b0, ld_valid}, 0);
    tick;
    req_valid = 1; opcode = 6'h23; addr = 32'h3000;
    push_req(32'h3000, 1, 4'b0, 32'h0); push_ld(6'h23, 2'd0);
    tick;
    opcode = 6'h21; addr = 32'h3006;
    push_req(32'h3004, 1, 4'b0, 32'h0); push_ld(6'h21, 2'd2);
    tick;
    opcode = 6'h0F; dc_stall = 1;
    @(negedge clk);
    chk("nop_mem_stall", {31'b0, mem_stall}, 0);
    chk("nop_dc_re", {31'b0, dc_re}, 0);
    tick;
    opcode = 6'h24; addr = 32'h4001;
    push_req(32'h4000, 1, 4'b0, 32'h0); push_ld(6'h24, 2'd1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("stall_mem_stall", {31'b0, mem_stall}, 1);
      chk("stall_dc_addr", dc_addr, 32'h4000);
      tick;
      opcode = 6'h2B; addr = 32'h8000;
    end
    dc_stall = 0; req_valid = 0;
    @(negedge clk);
    chk("accept_mem_stall", {31'b0, mem_stall}, 0);
    tick;
    @(negedge clk);
    chk("after_ld_valid", {31'b0, ld_valid}, 1);
    chk("short_stall_no_timeout", {31'b0, timeout_err}, 0);
    tick;
    req_valid = 1; opcode = 6'h2B; addr = 32'h5000; store_data = 32'hCAFEF00D; dc_stall = 1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("to_mem_stall", {31'b0, mem_stall}, 1);
      chk("to_dc_we", {28'b0, dc_we}, 32'hF);
      tick;
      req_valid = 0;
      chk("to_timeout", {31'b0, timeout_err}, (k >= 4) ? 32'h1 : 32'h0);
    end
    rst = 1;
    @(negedge clk);
    chk("hold_rst_dc_we", {28'b0, dc_we}, 0);
    chk("hold_rst_mem_stall", {31'b0, mem_stall}, 0);
    tick;
    rst = 0; dc_stall = 0;
    @(negedge clk);
    chk("post_rst_timeout", {31'b0, timeout_err}, 0);
    chk("post_rst_dc_re", {31'b0, dc_re}, 0);
    chk("post_rst_dc_we", {28'b0, dc_we}, 0);
    chk("post_rst_ld_valid", {31'b0, ld_valid}, 0);
    tick;
    tick;
    chk("req_queue_empty", rq.size(), 0);
    chk("ld_queue_empty", lq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
